// File: rtl/rr_pkg.sv
// Shared constants and state encoding for the round-robin request encoder.
package rr_pkg;
  localparam int WIDTH   = 4;
  localparam int N       = 1 << WIDTH;
  localparam int TMO_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_req_encoder_if.sv
// Request/grant bundle between requesters, the encoder and the downstream decoder.
interface rr_req_encoder_if
  import rr_pkg::*;
#(
  parameter int WIDTH = rr_pkg::WIDTH
);
  localparam int NREQ = 1 << WIDTH;

  logic [NREQ-1:0]  req;
  logic             ack;
  logic [WIDTH-1:0] ip;
  logic             valid;
  logic             tmo;

  modport master (output req, output ack, input ip, input valid, input tmo);
  modport slave  (input req, input ack, output ip, output valid, output tmo);
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import rr_pkg::*;
#(
  parameter int WIDTH = rr_pkg::WIDTH
) (
  input  logic [(1<<WIDTH)-1:0] req,
  input  logic [WIDTH-1:0]      ptr,
  output logic                  any,
  output logic [WIDTH-1:0]      win
);
  localparam int NREQ = 1 << WIDTH;

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [WIDTH-1:0]  w_idx;

  // Doubling the vector turns the right shift into a rotate.
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[NREQ-1:0];

  always_comb begin
    w_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_idx = WIDTH'(i);
    end
  end

  assign any = |req;
  assign win = w_idx + ptr;
endmodule

// File: rtl/rr_req_encoder.sv
// Round-robin request encoder: registered grant index held under valid/ack with timeout release.
module rr_req_encoder
  import rr_pkg::*;
#(
  parameter int WIDTH = rr_pkg::WIDTH,
  parameter int TMO   = rr_pkg::TMO_DEF
) (
  input  logic               clk,
  input  logic               rst,
  rr_req_encoder_if.slave    bus
);
  localparam int CNT_W = $clog2(TMO) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TMO == 0) ? '0 : CNT_W'(TMO - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_ip;
  logic             r_valid;
  logic             r_tmo;

  logic             w_any;
  logic [WIDTH-1:0] w_win;

  rr_pick #(.WIDTH(WIDTH)) u_pick (
    .req (bus.req),
    .ptr (r_ptr),
    .any (w_any),
    .win (w_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_ip    <= '0;
      r_valid <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_tmo <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_ip    <= w_win;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          // Ack takes priority over an expiring timeout, so tmo never fires with an ack.
          if (bus.ack) begin
            r_valid <= 1'b0;
            r_ptr   <= r_ip + 1'b1;
            r_state <= IDLE;
          end else if ((TMO != 0) && (r_cnt == CNT_LAST)) begin
            r_valid <= 1'b0;
            r_tmo   <= 1'b1;
            r_ptr   <= r_ip + 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ip    = r_ip;
  assign bus.valid = r_valid;
  assign bus.tmo   = r_tmo;
endmodule

// File: tb/tb_rr_req_encoder.sv
// Directed bench for rr_req_encoder with hand-computed grant sequences.
module tb_rr_req_encoder;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  rr_req_encoder_if #(.WIDTH(4)) bus ();

  rr_req_encoder #(.WIDTH(4), .TMO(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] ip, input logic t);
    chk({tag, ".valid"}, 32'(bus.valid), 32'(v));
    chk({tag, ".ip"},    32'(bus.ip),    32'(ip));
    chk({tag, ".tmo"},   32'(bus.tmo),   32'(t));
  endtask

  initial begin
    int exp_order [4];
    exp_order = '{0, 5, 15, 0};
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.ack = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b0, 4'd0, 1'b0);
    rst = 1'b0;

    // Idle with no requests
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out("idle", 1'b0, 4'd0, 1'b0);
    end

    // Round-robin over bits 0, 5, 15 with ack two cycles after each grant
    bus.req = 16'h8021;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk_out("rr_grant", 1'b1, 4'(exp_order[g]), 1'b0);
      tick();
      chk("rr_hold.valid", 32'(bus.valid), 32'd1);
      bus.ack = 1'b1;
      tick();
      chk("rr_gap.valid", 32'(bus.valid), 32'd0);
      bus.ack = 1'b0;
      if (g == 3) bus.req = '0;
    end

    // Timeout with ptr=1, only bit 3 requesting
    bus.req = 16'h0008;
    tick();
    chk_out("tmo_grant", 1'b1, 4'd3, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk_out("tmo_hold", 1'b1, 4'd3, 1'b0);
    end
    tick();
    chk_out("tmo_fire", 1'b0, 4'd3, 1'b1);
    tick();
    chk_out("tmo_regrant", 1'b1, 4'd3, 1'b0);
    bus.ack = 1'b1;
    tick();
    chk("tmo_ack.valid", 32'(bus.valid), 32'd0);
    bus.ack = 1'b0;

    // ptr=4: bits 15 and 2 -> 15, then wrap to 2
    bus.req = 16'h8004;
    tick();
    chk_out("wrap_g15", 1'b1, 4'd15, 1'b0);
    bus.ack = 1'b1;
    tick();
    chk("wrap_rel.valid", 32'(bus.valid), 32'd0);
    bus.ack = 1'b0;
    tick();
    chk_out("wrap_g2", 1'b1, 4'd2, 1'b0);
    bus.ack = 1'b1;
    bus.req = '0;
    tick();
    chk("wrap_rel2.valid", 32'(bus.valid), 32'd0);
    bus.ack = 1'b0;

    // ptr=3: ack on the expiry cycle beats the timeout
    bus.req = 16'h0010;
    tick();
    chk_out("race_grant", 1'b1, 4'd4, 1'b0);
    for (int i = 1; i < 8; i++) tick();
    chk_out("race_last", 1'b1, 4'd4, 1'b0);
    bus.ack = 1'b1;
    tick();
    chk_out("race_ack", 1'b0, 4'd4, 1'b0);
    bus.req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("idle_ack", 1'b0, 4'd4, 1'b0);
    end
    bus.ack = 1'b0;

    // ptr=5: grant 9 then reset mid-grant
    bus.req = 16'h0200;
    tick();
    chk_out("rst_pre", 1'b1, 4'd9, 1'b0);
    rst = 1'b1;
    tick();
    chk_out("rst_mid", 1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    bus.req = 16'hFFFF;
    tick();
    chk_out("rst_after", 1'b1, 4'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rr_req_encoder.md
# rr_req_encoder

Round-robin request arbiter and encoder that sits directly upstream of the 4-to-16 decoder. It samples 16 request lines, selects one fairly, and presents its registered 4-bit index to the decoder, which converts it back into a one-hot grant. The index is held stable under a valid/ack handshake, with a timeout that recovers from a consumer that never acknowledges.

## Interface
- `WIDTH`, 4: index width; request count N = 2**WIDTH = 16.
- `TMO`, 8: maximum cycles a grant may be held without ack; 0 disables the timeout.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active high.
- `req`  in  16  request lines; bit i set = requester i wants service.
- `ack`  in  1  consumer accepts the current index; sampled only while `valid`=1.
- `ip`  out  4  registered grant index; drives the decoder input directly.
- `valid`  out  1  `ip` holds a live grant.
- `tmo`  out  1  one-cycle pulse: grant released by timeout.

## Operation
- Internal state: FSM {IDLE, GRANT}, round-robin pointer `ptr`[3:0], hold counter `cnt`.
- Reset values: state IDLE, `ptr`=0, `cnt`=0, `ip`=0, `valid`=0, `tmo`=0.
- IDLE:
  - `req`==0: stay in IDLE; outputs unchanged (`valid`=0).
  - Otherwise: winner = first set bit scanning `ptr`, `ptr`+1, … 15, 0, … `ptr`-1 (mod 16). Register `ip`=winner, `valid`=1, `cnt`=0, go to GRANT.
- GRANT:
  - `ip` is frozen; changes on `req` are ignored, including withdrawal of the granted request.
  - `ack`=1: `valid`=0, `ptr`=`ip`+1 (mod 16, so 15 wraps to 0), go to IDLE.
  - `ack`=0, `TMO`≠0 and `cnt`==`TMO`-1: `valid`=0, `tmo`=1 for one cycle, `ptr`=`ip`+1, go to IDLE.
  - Otherwise: `cnt`=`cnt`+1.
- `ack` in IDLE is ignored.
- `ack` coinciding with timeout expiry: ack wins and `tmo` stays 0.
- `ip` retains the last granted value after release; consumers must qualify it with `valid`.
- `cnt` width is clog2(`TMO`)+1. It never exceeds `TMO`-1.

## Timing
- Request-to-grant latency is 1 cycle: a `req` sampled in IDLE at edge k gives `valid`=1 and `ip` after edge k.
- Ack-to-release is 1 cycle: `ack` sampled at edge k drops `valid` after edge k.
- The earliest new grant comes 1 cycle later, so there is always at least one `valid`=0 bubble between grants.
- Maximum `valid` high time without ack is `TMO` cycles. `tmo` is asserted in the first cycle after that, concurrent with `valid`=0.
- Reset mid-grant: on the next edge `valid`=0, `ip`=0, `ptr`=0, IDLE. No `tmo` pulse is generated.
- All outputs are registered; there is no combinational path from `req` or `ack` to any output.

## Structure
- Shared package `rr_pkg`:
  - `WIDTH`, `N` constants.
  - State enum {IDLE, GRANT}.
  - Default `TMO`.
- Sub-module `rr_pick` (combinational):
  - Inputs: `req`[15:0] and `ptr`[3:0].
  - Outputs: `any` and `win`[3:0].
  - Method: rotate `req` right by `ptr`, priority-encode the lowest set bit, add `ptr` mod 16.
- Top level holds the FSM, `ptr`, `cnt` and the output registers.
- Integration: `rr_req_encoder.ip` → decoder `ip`; decoder `op` is gated by `valid` to form the one-hot grant.

## Test plan
- Reset, then `req`=0 for 10 cycles → `valid`=0, `ip`=0, `tmo`=0 throughout.
- `req`=0x0000_8021 (bits 0, 5, 15) held, `ack` asserted 2 cycles after each grant → grant order `ip`=0, 5, 15, 0, with a one-cycle `valid`=0 gap between grants.
- `req` bit 3 only, `ack` never asserted, `TMO`=8 → `valid` high exactly 8 cycles, then `tmo`=1 for one cycle with `valid`=0. A regrant of 3 occurs next cycle.
- Grant `ip`=15 acked while `req` bits 15 and 2 are set → `ptr` wraps to 0 and the next grant is 2.
- `ack`=1 on the same cycle as `cnt`==`TMO`-1 → `valid` drops and `tmo` stays 0. Also: `ack`=1 in IDLE has no effect.
- `rst` asserted while `valid`=1, `ip`=9 → next cycle `valid`=0, `ip`=0. After release with `req`=all ones, the first grant is 0.
